// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline queue: default sizing, the clog2 helper
// and the per-cycle operation encoding used by the pointer/count logic.
package pipeline_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 2;
  localparam int DEF_STAT_W = 16;

  // Ceiling log2, usable in constant expressions (clog2(2)=1, clog2(4)=2).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // What the queue does this cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/pipeline_queue_if.sv
// Handshake bundle for the pipeline queue. The master side is the
// producer/consumer environment, the slave side is the queue itself.
interface pipeline_queue_if
  import pipeline_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int STAT_W = DEF_STAT_W
);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [clog2(DEPTH):0] count;
  logic [STAT_W-1:0]     bubble_cnt;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, bubble_cnt
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, bubble_cnt
  );

endinterface

// File: rtl/pipeline_queue_mem.sv
// Storage array for the pipeline queue: one synchronous write port and one
// asynchronous read port. Contents are undefined until written.
module pipeline_queue_mem
  import pipeline_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic [clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]        rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on an accepted push.
  // NOTE: no reset on the array -- occupancy lives in the count register, so
  // stale contents are never observable, and a resettable array would cost
  // a reset net per bit and block RAM inference. State is updated with <=
  // so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipeline_queue.sv
// Pipeline queue: a DEPTH-entry FIFO with registered ready/valid, flush,
// occupancy output and a saturating counter of consumer-starved cycles.
module pipeline_queue
  import pipeline_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int STAT_W = DEF_STAT_W
) (
  input logic             clk,
  input logic             rst,
  pipeline_queue_if.slave bus
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STAT_W-1:0] bubble_q, bubble_d;
  logic              push, pop;
  op_e               op;
  logic [WIDTH-1:0]  rd_data;

  // Handshake flags come from the count register only, so a full queue
  // cannot accept in the same cycle a pop frees a slot.
  assign bus.in_ready  = (count_q < CNT_W'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = bus.out_valid ? rd_data : '0;
  assign bus.count     = count_q;
  assign bus.bubble_cnt = bubble_q;

  assign push = bus.in_valid  && bus.in_ready  && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;
  assign op   = op_e'({push, pop});

  pipeline_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Next-state for pointers and occupancy; flush overrides push and pop.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (op)
        OP_PUSH: begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d  = count_q + CNT_W'(1);
        end
        OP_POP: begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
        end
        OP_BOTH: begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        OP_IDLE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state for the starved-consumer counter; saturates, ignores flush.
  always_comb begin
    bubble_d = bubble_q;
    if (bus.out_ready && !bus.out_valid && !bus.flush && (bubble_q != '1)) begin
      bubble_d = bubble_q + STAT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bubble_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bubble_q <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipeline_queue.sv
// Testbench for pipeline_queue: two instances (DEPTH=2/STAT_W=4 and
// DEPTH=4/STAT_W=16) driven with identical stimulus and compared every cycle
// against a queue-based reference model, plus directed scenario checks.
module tb_pipeline_queue;

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_queue_if #(.WIDTH(8), .DEPTH(2), .STAT_W(4))  bus_a ();
  pipeline_queue_if #(.WIDTH(8), .DEPTH(4), .STAT_W(16)) bus_b ();

  pipeline_queue #(.WIDTH(8), .DEPTH(2), .STAT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipeline_queue #(.WIDTH(8), .DEPTH(4), .STAT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain queues plus bubble counters.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  int         bub0, bub1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one model instance by one clock edge given this cycle's inputs.
  task automatic model_update(input int sel, input logic v, input logic [7:0] d,
                              input logic rdy, input logic fl);
    logic [7:0] q[$];
    int depth, bmax, b;
    bit can_push;
    if (sel == 0) begin q = mq0; depth = 2; bmax = 15;    b = bub0; end
    else          begin q = mq1; depth = 4; bmax = 65535; b = bub1; end
    if (fl) begin
      q.delete();
    end else begin
      can_push = v && (q.size() < depth);
      if (rdy && q.size() == 0 && b < bmax) b++;
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (can_push) q.push_back(d);
    end
    if (sel == 0) begin mq0 = q; bub0 = b; end
    else          begin mq1 = q; bub1 = b; end
  endtask

  task automatic check_one(input string n, input int sel, input logic ir, input logic ov,
                           input logic [7:0] od, input int cnt, input int bub);
    logic [7:0] q[$];
    int depth, b;
    logic [7:0] exp_od;
    if (sel == 0) begin q = mq0; depth = 2; b = bub0; end
    else          begin q = mq1; depth = 4; b = bub1; end
    exp_od = (q.size() != 0) ? q[0] : 8'h00;
    check({n, ".in_ready"},   32'(ir),  32'(q.size() < depth));
    check({n, ".out_valid"},  32'(ov),  32'(q.size() != 0));
    check({n, ".out_data"},   32'(od),  32'(exp_od));
    check({n, ".count"},      32'(cnt), 32'(q.size()));
    check({n, ".bubble_cnt"}, 32'(bub), 32'(b));
  endtask

  task automatic check_outputs();
    check_one("a", 0, bus_a.in_ready, bus_a.out_valid, bus_a.out_data,
              int'(bus_a.count), int'(bus_a.bubble_cnt));
    check_one("b", 1, bus_b.in_ready, bus_b.out_valid, bus_b.out_data,
              int'(bus_b.count), int'(bus_b.bubble_cnt));
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rdy, input logic fl);
    bus_a.in_valid = v;  bus_b.in_valid = v;
    bus_a.in_data  = d;  bus_b.in_data  = d;
    bus_a.out_ready = rdy; bus_b.out_ready = rdy;
    bus_a.flush    = fl; bus_b.flush    = fl;
  endtask

  // Called at a falling edge: apply inputs, step model, sample at next falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input logic fl);
    drive(v, d, rdy, fl);
    model_update(0, v, d, rdy, fl);
    model_update(1, v, d, rdy, fl);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  logic [7:0] got[$];
  int         max_cnt;
  logic       r_v, r_rdy, r_fl;
  logic [7:0] r_d;
  int         phase;

  initial begin
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bub0 = 0;
    bub1 = 0;

    // Outputs while held in reset.
    repeat (2) @(negedge clk);
    check_outputs();

    // Reset release, idle.
    rst = 1'b1;
    @(negedge clk);
    check_outputs();
    check("idle.a.in_ready",  32'(bus_a.in_ready),  32'd1);
    check("idle.a.out_data",  32'(bus_a.out_data),  32'd0);
    check("idle.b.bubble",    32'(bus_b.bubble_cnt), 32'd0);

    // Starved consumer: 4-bit counter saturates, flush leaves it alone.
    repeat (20) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("sat.a.bubble", 32'(bus_a.bubble_cnt), 32'd15);
    check("sat.b.bubble", 32'(bus_b.bubble_cnt), 32'd20);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("sat.a.bubble_after_flush", 32'(bus_a.bubble_cnt), 32'd15);

    // Full DEPTH=2 queue refuses a push in the cycle it is popped.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    check("full.a.count",    32'(bus_a.count),    32'd2);
    check("full.a.in_ready", 32'(bus_a.in_ready), 32'd0);
    check("full.a.out_data", 32'(bus_a.out_data), 32'hA5);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    check("full.a.in_ready_after_pop", 32'(bus_a.in_ready), 32'd1);
    check("full.a.out_data_after_pop", 32'(bus_a.out_data), 32'h3C);
    check("full.a.count_after_pop",    32'(bus_a.count),    32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("full.a.77_refused", 32'(bus_a.out_valid), 32'd0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming through DEPTH=4: push and pop every cycle, order and wrap.
    got.delete();
    max_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (bus_b.out_valid) got.push_back(bus_b.out_data);
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
      if (int'(bus_b.count) > max_cnt) max_cnt = int'(bus_b.count);
    end
    for (int i = 0; i < 2; i++) begin
      if (bus_b.out_valid) got.push_back(bus_b.out_data);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("stream.b.max_count", 32'(max_cnt),    32'd1);
    check("stream.b.n_out",     32'(got.size()), 32'd10);
    for (int i = 0; i < got.size(); i++) begin
      check($sformatf("stream.b.data%0d", i), 32'(got[i]), 32'(i + 1));
    end

    // Flush beats a simultaneous push.
    repeat (3) cycle(1'b1, 8'h11, 1'b0, 1'b0);
    check("flush.b.count_before", 32'(bus_b.count), 32'd3);
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    check("flush.b.count",     32'(bus_b.count),     32'd0);
    check("flush.b.out_valid", 32'(bus_b.out_valid), 32'd0);
    check("flush.b.out_data",  32'(bus_b.out_data),  32'd0);
    check("flush.a.count",     32'(bus_a.count),     32'd0);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush.b.no_99", 32'(bus_b.out_valid), 32'd0);

    // Asynchronous reset mid-cycle with two entries held.
    cycle(1'b1, 8'h21, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    check("arst.a.count_before", 32'(bus_a.count), 32'd2);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check("arst.a.count",     32'(bus_a.count),     32'd0);
    check("arst.a.out_valid", 32'(bus_a.out_valid), 32'd0);
    check("arst.b.count",     32'(bus_b.count),     32'd0);
    check("arst.b.out_data",  32'(bus_b.out_data),  32'd0);
    check("arst.b.bubble",    32'(bus_b.bubble_cnt), 32'd0);
    mq0.delete();
    mq1.delete();
    bub0 = 0;
    bub1 = 0;
    @(negedge clk);
    rst = 1'b1;
    check_outputs();
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);
    check("arst.a.first_out", 32'(bus_a.out_data), 32'h31);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("arst.a.second_out", 32'(bus_a.out_data), 32'h32);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with phases of slow, balanced and eager consumer.
    for (int i = 0; i < 3000; i++) begin
      phase = (i / 250) % 3;
      r_v   = ($urandom_range(0, 3) != 0);
      r_d   = 8'($urandom);
      case (phase)
        0:       r_rdy = ($urandom_range(0, 3) == 0);
        1:       r_rdy = ($urandom_range(0, 1) == 0);
        default: r_rdy = ($urandom_range(0, 3) != 0);
      endcase
      r_fl = ($urandom_range(0, 63) == 0);
      cycle(r_v, r_d, r_rdy, r_fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_queue.md
PIPELINE_QUEUE -- requirements
Module: pipeline_queue

Interface
REQ-001 Parameter WIDTH, default 32: payload bits per entry.
REQ-002 Parameter DEPTH, default 2: entry count; power of two, minimum 2.
REQ-003 Parameter STAT_W, default 16: width of the bubble statistics counter.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 flush  in  1  discard all entries.
REQ-008 in_valid  in  1  producer offers in_data.
REQ-009 in_ready  out  1  queue accepts this cycle.
REQ-010 in_data  in  WIDTH  producer payload.
REQ-011 out_valid  out  1  head entry present.
REQ-012 out_ready  in  1  consumer takes head.
REQ-013 out_data  out  WIDTH  head payload.
REQ-014 count  out  clog2(DEPTH)+1  current occupancy.
REQ-015 bubble_cnt  out  STAT_W  saturating count of consumer-starved cycles.

Function
REQ-016 push = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
REQ-017 in_ready SHALL be (count < DEPTH), derived from registered state only; no combinational path from out_ready.
REQ-018 Full queue: push refused even when pop occurs in the same cycle; in_ready rises the cycle after that pop.
REQ-019 out_valid SHALL be (count != 0), registered state only.
REQ-020 out_data SHALL be the entry at the read pointer when out_valid=1, and all zeros when out_valid=0.
REQ-021 Latency: data pushed at edge N is visible on out_data after edge N; no same-cycle bypass.
REQ-022 Ordering is strictly FIFO.
REQ-023 Push only: write pointer increments and count increments.
REQ-024 Pop only: read pointer increments and count decrements.
REQ-025 Simultaneous push and pop on a non-empty, non-full queue: both pointers advance and count is unchanged.
REQ-026 Pointers SHALL wrap modulo DEPTH; there is no full/empty ambiguity because count is the authority.
REQ-027 Flush SHALL, at the next edge, set count=0 and both pointers to 0; it takes priority over push and pop in the same cycle.
REQ-028 Storage contents are not cleared on flush; out_data zeroing follows from REQ-020.
REQ-029 bubble_cnt SHALL increment when out_ready=1, out_valid=0 and flush=0, and saturate at all ones.
REQ-030 bubble_cnt is not cleared by flush.
REQ-031 A pop on an empty queue or a push on a full queue SHALL have no effect on state.

Reset
REQ-032 When rst=0, the block SHALL asynchronously set count=0, both pointers to 0 and bubble_cnt=0.
REQ-033 Resulting output values during and after reset: out_valid=0, out_data=0, in_ready=1.
REQ-034 Reset asserted mid-transfer SHALL discard all entries, with no partial-entry visibility after release.
REQ-035 Storage array needs no reset.

Structure
REQ-036 A shared package pipeline_pkg SHALL hold the clog2 helper and the default WIDTH, DEPTH and STAT_W constants.
REQ-037 The storage array SHALL be a sub-module pipeline_queue_mem: one write port, one asynchronous read port, no reset.
REQ-038 Pointer, count and statistics logic SHALL reside in pipeline_queue.

Verification
REQ-039 Reset release, idle: in_ready=1, out_valid=0, out_data=0, count=0, bubble_cnt=0.
REQ-040 DEPTH=2, with out_ready=0: push A5, then 3C. Required: count=2, in_ready=0. Then offer 77 while popping A5: 77 is refused; next cycle in_ready=1 and out_data=3C.
REQ-041 DEPTH=4, continuous push 1..10 and pop every cycle. Required: output sequence 1..10 in order, count never exceeds 1, pointers wrap with no loss.
REQ-042 Fill with 3 entries, then assert flush together with in_valid (data 99). Required: next cycle count=0, out_valid=0, out_data=0; 99 never appears at the output.
REQ-043 STAT_W=4, queue empty, out_ready=1 for 20 cycles. Required: bubble_cnt saturates at 15; a subsequent flush leaves it at 15.
REQ-044 Assert rst low asynchronously mid-cycle while count=2. Required: immediate count=0 and out_valid=0; after release, the first pushed value is the first one popped.
